// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : parametrised multi-cycle ALU with valid/ready handshakes.
//
// Holds one operation at a time. ADD/SUB/AND/OR/XOR/NOT and illegal opcodes
// finish straight from IDLE. MUL/MULH use a shift-add datapath, one bit per
// cycle. DIV/MOD use restoring division, one bit per cycle. All outputs are
// registered, and the result stays stable until the consumer accepts it.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands/opcode valid
//   in_ready   out  1      high only while IDLE
//   a, b       in   WIDTH  operands (captured on accept)
//   op         in   5      opcode
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  result
//   zero       out  1      result == 0
//   carry      out  1      ADD carry-out / SUB borrow
//   overflow   out  1      ADD/SUB signed overflow; MUL/MULH high half != 0
//   div_zero   out  1      DIV/MOD issued with b == 0
//   illegal    out  1      unrecognised opcode
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b00101;
  localparam logic [4:0] OP_MULH = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOD  = 5'b01001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    is_zero = (v == {WIDTH{1'b0}});
  endfunction

  // State and datapath registers
  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;       // MUL: product high half; DIV: partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // MUL: multiplier/product low half; DIV: dividend/quotient
  logic [WIDTH-1:0] opb_q, opb_d;     // captured operand B (multiplicand / divisor)
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             div_zero_q, div_zero_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  // Single-cycle decode of the live inputs
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] sc_result_s;
  logic             sc_carry_s;
  logic             sc_overflow_s;
  logic             sc_div_zero_s;
  logic             sc_illegal_s;
  logic             sc_is_mul_s;
  logic             sc_is_div_s;

  // Iterative step values
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_hi_s;
  logic [WIDTH-1:0] div_lo_s;

  // Decode of the opcode and operands presented in IDLE
  always_comb begin
    add_s         = {1'b0, a} + {1'b0, b};
    sub_s         = a - b;
    sc_result_s   = {WIDTH{1'b0}};
    sc_carry_s    = 1'b0;
    sc_overflow_s = 1'b0;
    sc_div_zero_s = 1'b0;
    sc_illegal_s  = 1'b0;
    sc_is_mul_s   = 1'b0;
    sc_is_div_s   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result_s   = add_s[WIDTH-1:0];
        sc_carry_s    = add_s[WIDTH];
        // Same-sign operands producing an opposite-sign sum
        sc_overflow_s = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result_s   = sub_s;
        sc_carry_s    = (a < b);
        // Opposite-sign operands where the difference takes b's sign
        sc_overflow_s = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_result_s = a & b;
      OP_OR:   sc_result_s = a | b;
      OP_XOR:  sc_result_s = a ^ b;
      OP_NOT:  sc_result_s = ~a;
      OP_MUL, OP_MULH: sc_is_mul_s = 1'b1;
      OP_DIV, OP_MOD: begin
        if (is_zero(b)) begin
          // Divide by zero completes at once: quotient all-ones, remainder = a
          sc_div_zero_s = 1'b1;
          sc_result_s   = (op == OP_MOD) ? a : {WIDTH{1'b1}};
        end else begin
          sc_is_div_s   = 1'b1;
        end
      end
      default: sc_illegal_s = 1'b1;
    endcase
  end

  // One shift-add multiply step and one restoring-division step
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_hi_s    = mul_sum_s[WIDTH:1];
    mul_lo_s    = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    div_shift_s = {hi_q, lo_q[WIDTH-1]};
    if (div_shift_s >= {1'b0, opb_q}) begin
      // Trial subtraction fits: the remainder is below the divisor, so WIDTH bits suffice
      div_hi_s = div_shift_s[WIDTH-1:0] - opb_q;
      div_lo_s = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = div_shift_s[WIDTH-1:0];
      div_lo_s = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and next-output logic for the control FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    op_d        = op_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = op;
          opb_d      = b;
          cnt_d      = CNTW'(WIDTH);
          in_ready_d = 1'b0;
          if (sc_is_mul_s) begin
            hi_d    = {WIDTH{1'b0}};
            lo_d    = a;
            state_d = S_MUL;
          end else if (sc_is_div_s) begin
            hi_d    = {WIDTH{1'b0}};
            lo_d    = a;
            state_d = S_DIV;
          end else begin
            result_d    = sc_result_s;
            zero_d      = is_zero(sc_result_s);
            carry_d     = sc_carry_s;
            overflow_d  = sc_overflow_s;
            div_zero_d  = sc_div_zero_s;
            illegal_d   = sc_illegal_s;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        hi_d  = mul_hi_s;
        lo_d  = mul_lo_s;
        cnt_d = cnt_q - CNTW'(1);
        // The last step publishes straight from the step values
        if (cnt_q == CNTW'(1)) begin
          result_d    = (op_q == OP_MULH) ? mul_hi_s : mul_lo_s;
          zero_d      = is_zero((op_q == OP_MULH) ? mul_hi_s : mul_lo_s);
          carry_d     = 1'b0;
          overflow_d  = !is_zero(mul_hi_s);
          div_zero_d  = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        hi_d  = div_hi_s;
        lo_d  = div_lo_s;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          result_d    = (op_q == OP_MOD) ? div_hi_s : div_lo_s;
          zero_d      = is_zero((op_q == OP_MOD) ? div_hi_s : div_lo_s);
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          div_zero_d  = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNTW{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      op_q        <= 5'b00000;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (WIDTH=16).
// Directed cases plus randomized operations, checked against an arithmetic
// reference model; also exercises backpressure and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [4:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        div_zero;
  logic        illegal;

  int n_cmp;
  int n_err;

  alu_mc #(.WIDTH(16), .CNTW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 16-bit values
  task automatic model(input logic [15:0] ta, input logic [15:0] tb_v, input logic [4:0] top,
                       output logic [15:0] r, output logic c, output logic o,
                       output logic dz, output logic il, output int lat);
    int     ua, ub, sa, sb, s;
    longint p;
    ua = int'(ta); ub = int'(tb_v);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r = 16'h0000; c = 1'b0; o = 1'b0; dz = 1'b0; il = 1'b0; lat = 1;
    case (top)
      5'd0: begin
        s = ua + ub; r = 16'(s % 65536); c = (s > 65535);
        s = sa + sb; o = (s > 32767) || (s < -32768);
      end
      5'd1: begin
        s = ua - ub + 65536; r = 16'(s % 65536); c = (ua < ub);
        s = sa - sb; o = (s > 32767) || (s < -32768);
      end
      5'd2: r = ta & tb_v;
      5'd3: r = ta | tb_v;
      5'd4: r = ta ^ tb_v;
      5'd5, 5'd6: begin
        p = longint'(ua) * longint'(ub);
        r = (top == 5'd5) ? 16'(p % 65536) : 16'(p / 65536);
        o = ((p / 65536) != 0);
        lat = 17;
      end
      5'd7, 5'd9: begin
        if (ub == 0) begin
          dz = 1'b1;
          r = (top == 5'd7) ? 16'hFFFF : ta;
        end else begin
          r = (top == 5'd7) ? 16'(ua / ub) : 16'(ua % ub);
          lat = 17;
        end
      end
      5'd8: r = ~ta;
      default: il = 1'b1;
    endcase
  endtask

  // Issue one operation, check latency and outputs, optionally stall the consumer
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [4:0] top,
                       input int hold, input string tag);
    logic [15:0] er;
    logic ec, eo, ed, ei;
    int   elat, lat, n;
    model(ta, tb_v, top, er, ec, eo, ed, ei, elat);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".latency"},  32'(lat),      32'(elat));
    check_eq({tag, ".result"},   32'(result),   32'(er));
    check_eq({tag, ".zero"},     32'(zero),     32'(er == 16'h0000));
    check_eq({tag, ".carry"},    32'(carry),    32'(ec));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(eo));
    check_eq({tag, ".div_zero"}, 32'(div_zero), 32'(ed));
    check_eq({tag, ".illegal"},  32'(illegal),  32'(ei));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); op = 5'($urandom_range(0, 4));
      @(posedge clk); #1;
      check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, ".hold_ready"}, 32'(in_ready),  32'd0);
      check_eq({tag, ".hold_res"},   32'(result),    32'(er));
      check_eq({tag, ".hold_flags"}, {27'd0, zero, carry, overflow, div_zero, illegal},
               {27'd0, (er == 16'h0000), ec, eo, ed, ei});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".post_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0000; b = 16'h0000; op = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.in_ready",  32'(in_ready),  32'd1);
    check_eq("rst.result",    32'(result),    32'd0);
    check_eq("rst.flags", {27'd0, zero, carry, overflow, div_zero, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(16'hFFFF, 16'h0001, 5'b00000, 0, "add_wrap");
    do_op(16'h8000, 16'h0001, 5'b00001, 0, "sub_ovf");
    do_op(16'h0003, 16'h0005, 5'b00001, 0, "sub_borrow");
    do_op(16'h1234, 16'h0100, 5'b00101, 0, "mul");
    do_op(16'h1234, 16'h0100, 5'b00110, 0, "mulh");
    do_op(16'h0009, 16'h0004, 5'b00111, 0, "div");
    do_op(16'h0009, 16'h0004, 5'b01001, 0, "mod");
    do_op(16'h0009, 16'h0000, 5'b00111, 0, "div0");
    do_op(16'h0009, 16'h0000, 5'b01001, 0, "mod0");
    do_op(16'hFFFF, 16'hFFFF, 5'b00101, 5, "mul_hold");
    do_op(16'hA5A5, 16'h0000, 5'b01000, 0, "not");
    do_op(16'h7FFF, 16'h0001, 5'b00000, 0, "add_ovf");

    // Reset in the middle of a DIV
    @(negedge clk);
    a = 16'h0009; b = 16'h0004; op = 5'b00111; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst.out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst.result",    32'(result),    32'd0);
    check_eq("midrst.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check_eq("midrst.no_output", 32'(seen), 32'd0);
    end
    do_op(16'h1111, 16'h2222, 5'b11111, 0, "illegal");

    // Randomized operations, including illegal opcodes and zero divisors
    for (int i = 0; i < 80; i++) begin
      logic [15:0] ra, rb;
      logic [4:0]  rop;
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
      do_op(ra, rb, rop, int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
